// File: rtl/motion_pkg.sv
// motion_pkg: shared types and constants for the per-frame motion controller.
//   mstate_t : jump state encoding (GROUND=0, RISE=1, FALL=2)
//   VEL_W    : velocity word width (two's complement)
//   KEY_*    : USB HID keycodes for left / right / jump
package motion_pkg;

    localparam int VEL_W = 10;

    localparam logic [7:0] KEY_LEFT  = 8'd4;
    localparam logic [7:0] KEY_RIGHT = 8'd7;
    localparam logic [7:0] KEY_JUMP  = 8'd26;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } mstate_t;

endpackage

// File: rtl/motion_ctrl_if.sv
// motion_ctrl_if: velocity command handshake toward the position datapath.
//   cmd_valid : command pending (driven by master)
//   cmd_ready : datapath accepts the command (driven by slave)
//   vel_x     : signed x velocity, + = right
//   vel_y     : signed y velocity, + = down
interface motion_ctrl_if;
    import motion_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [VEL_W-1:0] vel_x;
    logic [VEL_W-1:0] vel_y;

    modport master (output cmd_valid, output vel_x, output vel_y, input cmd_ready);
    modport slave  (input cmd_valid, input vel_x, input vel_y, output cmd_ready);

endinterface

// File: rtl/key_edge.sv
// key_edge: per-frame press-edge detector.
//   Clk       : system clock
//   Reset     : synchronous active-high reset
//   sample_en : frame evaluation strobe; the latch only updates here
//   key_match : key of interest is currently down
//   press     : key down now and was not down at the previous evaluated frame
module key_edge (
    input  logic Clk,
    input  logic Reset,
    input  logic sample_en,
    input  logic key_match,
    output logic press
);

    logic latch_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            latch_q <= 1'b0;
        end else if (sample_en) begin
            latch_q <= key_match;
        end
    end

    // Combinational so the press is seen in the same evaluation that samples it.
    assign press = key_match & ~latch_q;

endmodule

// File: rtl/motion_ctrl.sv
// motion_ctrl: samples the keycode once per frame, runs the ground/rise/fall
// jump FSM and issues one signed velocity command per frame.
//   Clk, Reset  : system clock, synchronous active-high reset
//   frame_tick  : one-cycle pulse per video frame
//   keycode     : current keycode, 0 = no key
//   on_ground   : sprite resting on a surface
//   at_ceiling  : sprite top touching an obstacle
//   cmd         : velocity command handshake (master side)
//   mstate      : current FSM state
//   facing      : 1 = right, 0 = left
//   overrun     : sticky, a frame was dropped under backpressure
//
// state  | meaning
// GROUND | standing; may start a jump or walk off an edge
// RISE   | airborne moving up, vel_y < 0
// FALL   | airborne moving down, vel_y saturates at VMAX_FALL
module motion_ctrl
    import motion_pkg::*;
#(
    parameter int unsigned X_STEP    = 2,
    parameter int unsigned JUMP_VEL  = 10,
    parameter int unsigned GRAVITY   = 1,
    parameter int unsigned VMAX_FALL = 8
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                frame_tick,
    input  logic [7:0]          keycode,
    input  logic                on_ground,
    input  logic                at_ceiling,
    motion_ctrl_if.master       cmd,
    output logic [1:0]          mstate,
    output logic                facing,
    output logic                overrun
);

    localparam logic [VEL_W-1:0] X_STEP_V   = VEL_W'(X_STEP);
    localparam logic [VEL_W-1:0] JUMP_VEL_V = VEL_W'(JUMP_VEL);
    localparam logic [VEL_W-1:0] GRAVITY_V  = VEL_W'(GRAVITY);
    localparam logic [VEL_W-1:0] VMAX_V     = VEL_W'(VMAX_FALL);

    mstate_t           state_q;
    logic              eval;
    logic              jump_req;
    logic signed [VEL_W:0] vy_sum;

    // A frame is evaluated only when the previous command is gone or leaving now.
    assign eval = frame_tick & (~cmd.cmd_valid | cmd.cmd_ready);

    key_edge u_jump_edge (
        .Clk       (Clk),
        .Reset     (Reset),
        .sample_en (eval),
        .key_match (keycode == KEY_JUMP),
        .press     (jump_req)
    );

    // One extra bit so vel_y + GRAVITY cannot wrap before the signed compares.
    assign vy_sum = $signed({cmd.vel_y[VEL_W-1], cmd.vel_y}) + $signed({1'b0, GRAVITY_V});

    assign mstate = state_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= GROUND;
            cmd.vel_x     <= '0;
            cmd.vel_y     <= '0;
            cmd.cmd_valid <= 1'b0;
            facing        <= 1'b1;
            overrun       <= 1'b0;
        end else begin
            if (frame_tick && cmd.cmd_valid && !cmd.cmd_ready) begin
                overrun <= 1'b1;
            end

            if (eval) begin
                cmd.cmd_valid <= 1'b1;

                if (keycode == KEY_LEFT) begin
                    cmd.vel_x <= '0 - X_STEP_V;
                    facing    <= 1'b0;
                end else if (keycode == KEY_RIGHT) begin
                    cmd.vel_x <= X_STEP_V;
                    facing    <= 1'b1;
                end else begin
                    cmd.vel_x <= '0;
                end

                case (state_q)
                    GROUND: begin
                        if (jump_req && !at_ceiling) begin
                            state_q   <= RISE;
                            cmd.vel_y <= '0 - JUMP_VEL_V;
                        end else if (!on_ground) begin
                            state_q   <= FALL;
                            cmd.vel_y <= GRAVITY_V;
                        end else begin
                            cmd.vel_y <= '0;
                        end
                    end
                    RISE: begin
                        if (at_ceiling) begin
                            state_q   <= FALL;
                            cmd.vel_y <= '0;
                        end else begin
                            cmd.vel_y <= vy_sum[VEL_W-1:0];
                            if (!vy_sum[VEL_W]) begin
                                state_q <= FALL;
                            end
                        end
                    end
                    FALL: begin
                        if (on_ground) begin
                            state_q   <= GROUND;
                            cmd.vel_y <= '0;
                        end else if (vy_sum > $signed({1'b0, VMAX_V})) begin
                            cmd.vel_y <= VMAX_V;
                        end else begin
                            cmd.vel_y <= vy_sum[VEL_W-1:0];
                        end
                    end
                    default: begin
                        state_q   <= GROUND;
                        cmd.vel_y <= '0;
                    end
                endcase
            end else if (cmd.cmd_ready) begin
                cmd.cmd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_motion_ctrl.sv
// tb_motion_ctrl: directed stimulus with a queue scoreboard for accepted
// velocity commands plus direct checks of reset, backpressure and overrun.
module tb_motion_ctrl;
    import motion_pkg::*;

    typedef struct packed {
        logic [9:0] vx;
        logic [9:0] vy;
        logic [1:0] st;
        logic       f;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_tick;
    logic [7:0] keycode;
    logic       on_ground;
    logic       at_ceiling;
    logic [1:0] mstate;
    logic       facing;
    logic       overrun;

    motion_ctrl_if cmd_if ();

    motion_ctrl dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .keycode    (keycode),
        .on_ground  (on_ground),
        .at_ceiling (at_ceiling),
        .cmd        (cmd_if),
        .mstate     (mstate),
        .facing     (facing),
        .overrun    (overrun)
    );

    always #10 Clk = ~Clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic logic [9:0] v10(input int x);
        return x[9:0];
    endfunction

    function automatic exp_t mk(input int vx, input int vy, input int st, input int f);
        exp_t e;
        e.vx = v10(vx);
        e.vy = v10(vy);
        e.st = st[1:0];
        e.f  = f[0];
        return e;
    endfunction

    // Monitor: a command is accepted on the next posedge whenever valid && ready.
    always @(negedge Clk) begin
        if (!Reset && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_cmd", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("cmd_vel_x",  int'(cmd_if.vel_x), int'(e.vx));
                check("cmd_vel_y",  int'(cmd_if.vel_y), int'(e.vy));
                check("cmd_mstate", int'(mstate),       int'(e.st));
                check("cmd_facing", int'(facing),       int'(e.f));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
    endtask

    task automatic frame(input logic [7:0] kc, input logic og, input logic ceil, input logic rdy);
        @(posedge Clk);
        #1;
        keycode          = kc;
        on_ground        = og;
        at_ceiling       = ceil;
        cmd_if.cmd_ready = rdy;
        frame_tick       = 1'b1;
        @(posedge Clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic fr(input logic [7:0] kc, input logic og, input logic ceil, input exp_t e);
        exp_q.push_back(e);
        frame(kc, og, ceil, 1'b1);
        idle(2);
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk);
        #1 Reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_mstate"},  int'(mstate),           0);
        check({tag, "_vel_x"},   int'(cmd_if.vel_x),     0);
        check({tag, "_vel_y"},   int'(cmd_if.vel_y),     0);
        check({tag, "_valid"},   int'(cmd_if.cmd_valid), 0);
        check({tag, "_facing"},  int'(facing),           1);
        check({tag, "_overrun"}, int'(overrun),          0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset            = 1'b1;
        frame_tick       = 1'b0;
        keycode          = 8'd0;
        on_ground        = 1'b1;
        at_ceiling       = 1'b0;
        cmd_if.cmd_ready = 1'b1;
        idle(2);
        #1 Reset = 1'b0;
        check_reset_state("reset");

        // Horizontal control.
        fr(8'd4, 1'b1, 1'b0, mk(-2, 0, 0, 0));
        fr(8'd0, 1'b1, 1'b0, mk( 0, 0, 0, 0));
        fr(8'd7, 1'b1, 1'b0, mk( 2, 0, 0, 1));

        // Full jump arc with the jump key held throughout.
        fr(8'd26, 1'b1, 1'b0, mk(0, -10, 1, 1));
        for (int v = -9; v <= -1; v++) fr(8'd26, 1'b0, 1'b0, mk(0, v, 1, 1));
        fr(8'd26, 1'b0, 1'b0, mk(0, 0, 2, 1));
        for (int v = 1; v <= 8; v++) fr(8'd26, 1'b0, 1'b0, mk(0, v, 2, 1));
        fr(8'd26, 1'b0, 1'b0, mk(0, 8, 2, 1));
        fr(8'd26, 1'b0, 1'b0, mk(0, 8, 2, 1));
        fr(8'd26, 1'b1, 1'b0, mk(0, 0, 0, 1));
        fr(8'd26, 1'b1, 1'b0, mk(0, 0, 0, 1));

        // Ceiling hit during rise.
        fr(8'd0,  1'b1, 1'b0, mk(0,   0, 0, 1));
        fr(8'd26, 1'b1, 1'b0, mk(0, -10, 1, 1));
        fr(8'd26, 1'b0, 1'b0, mk(0,  -9, 1, 1));
        fr(8'd26, 1'b0, 1'b0, mk(0,  -8, 1, 1));
        fr(8'd26, 1'b0, 1'b0, mk(0,  -7, 1, 1));
        fr(8'd26, 1'b0, 1'b1, mk(0,   0, 2, 1));
        check("ceiling_mstate", int'(mstate), 2);
        fr(8'd26, 1'b0, 1'b0, mk(0,   1, 2, 1));
        fr(8'd0,  1'b1, 1'b0, mk(0,   0, 0, 1));

        // Reset in the middle of a rise with vel_y = -6.
        fr(8'd4,  1'b1, 1'b0, mk(-2,   0, 0, 0));
        fr(8'd26, 1'b1, 1'b0, mk( 0, -10, 1, 0));
        fr(8'd26, 1'b0, 1'b0, mk( 0,  -9, 1, 0));
        fr(8'd26, 1'b0, 1'b0, mk( 0,  -8, 1, 0));
        fr(8'd26, 1'b0, 1'b0, mk( 0,  -7, 1, 0));
        fr(8'd26, 1'b0, 1'b0, mk( 0,  -6, 1, 0));
        check("prerst_mstate", int'(mstate),       1);
        check("prerst_vel_y",  int'(cmd_if.vel_y), int'(v10(-6)));
        check("prerst_facing", int'(facing),       0);
        do_reset();
        check_reset_state("midjump_reset");

        // Backpressure: second tick dropped, overrun sticky.
        exp_q.push_back(mk(2, 0, 0, 1));
        frame(8'd7, 1'b1, 1'b0, 1'b0);
        check("bp_valid1", int'(cmd_if.cmd_valid), 1);
        check("bp_overrun1", int'(overrun), 0);
        idle(1);
        frame(8'd4, 1'b0, 1'b0, 1'b0);
        check("bp_vel_x",   int'(cmd_if.vel_x),     2);
        check("bp_vel_y",   int'(cmd_if.vel_y),     0);
        check("bp_mstate",  int'(mstate),           0);
        check("bp_facing",  int'(facing),           1);
        check("bp_valid2",  int'(cmd_if.cmd_valid), 1);
        check("bp_overrun2", int'(overrun),         1);
        @(posedge Clk);
        #1 cmd_if.cmd_ready = 1'b1;
        @(posedge Clk);
        #1;
        check("bp_release_valid",   int'(cmd_if.cmd_valid), 0);
        check("bp_release_overrun", int'(overrun),          1);
        idle(1);
        do_reset();
        check("rst_clears_overrun", int'(overrun), 0);

        // Accept and tick on the same edge.
        exp_q.push_back(mk(0, 0, 0, 1));
        frame(8'd0, 1'b1, 1'b0, 1'b0);
        idle(2);
        exp_q.push_back(mk(0, -10, 1, 1));
        frame(8'd26, 1'b1, 1'b0, 1'b1);
        check("same_edge_valid",   int'(cmd_if.cmd_valid), 1);
        check("same_edge_vel_y",   int'(cmd_if.vel_y),     int'(v10(-10)));
        check("same_edge_mstate",  int'(mstate),           1);
        check("same_edge_overrun", int'(overrun),          0);
        idle(4);
        check("same_edge_drain_valid", int'(cmd_if.cmd_valid), 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
